// File: rtl/game_io_pkg.sv
// Shared definitions for the board-side button conditioning logic:
// one-hot FSM state codes, default timing constants and a counter sizing helper.
package game_io_pkg;

  // Default channel count and timing at 100 MHz
  localparam int DEFAULT_N_BTN           = 4;
  localparam int DEFAULT_DEBOUNCE_CYCLES = 1_000_000;   // 10 ms
  localparam int DEFAULT_REPEAT_DELAY    = 50_000_000;  // 500 ms
  localparam int DEFAULT_REPEAT_PERIOD   = 10_000_000;  // 100 ms

  // One-hot state encoding, same style as the game-logic FSMs
  typedef logic [3:0] state_t;
  localparam state_t ST_IDLE         = 4'b0001;
  localparam state_t ST_PRESS_WAIT   = 4'b0010;
  localparam state_t ST_HELD         = 4'b0100;
  localparam state_t ST_RELEASE_WAIT = 4'b1000;

  // Counter width: $clog2 of the largest timing constant, plus one bit
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/button_conditioner_if.sv
// Button bundle between the push-button pins and the game logic.
// master: the board/stimulus side; slave: the conditioner.
interface button_conditioner_if
  import game_io_pkg::*;
#(
  parameter int N_BTN = DEFAULT_N_BTN
);
  logic [N_BTN-1:0] btn_raw;  // raw bouncy levels, asynchronous
  logic [N_BTN-1:0] DPBs;     // debounced levels
  logic [N_BTN-1:0] SCENs;    // single pulse per accepted press
  logic [N_BTN-1:0] MCENs;    // press pulse plus auto-repeat pulses

  modport master (output btn_raw, input DPBs, SCENs, MCENs);
  modport slave  (input btn_raw, output DPBs, SCENs, MCENs);
endinterface

// File: rtl/debounce_channel.sv
// One button channel: 2-flop synchroniser, debounce/auto-repeat FSM and
// registered level, press-pulse and repeat-pulse outputs.
module debounce_channel
  import game_io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEFAULT_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEFAULT_REPEAT_PERIOD
) (
  input  logic clk,
  input  logic reset,      // asynchronous, active-low
  input  logic btn_raw_i,
  output logic dpb_o,
  output logic scen_o,
  output logic mcen_o
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);
  typedef logic [CW-1:0] cnt_t;

  localparam cnt_t DEB_LAST    = cnt_t'(DEBOUNCE_CYCLES - 1);
  localparam cnt_t DELAY_LAST  = cnt_t'(REPEAT_DELAY - 1);
  localparam cnt_t PERIOD_LAST = cnt_t'(REPEAT_PERIOD - 1);

  logic   s1_q, s2_q;
  state_t state_q, state_d;
  cnt_t   cnt_q, cnt_d;      // press / release debounce count
  cnt_t   rcnt_q, rcnt_d;    // repeat count, survives release glitches
  logic   first_q, first_d;  // first repeat pulse already issued
  logic   dpb_q, dpb_d;
  logic   scen_q, scen_d;
  logic   mcen_q, mcen_d;

  // Shared decision terms for next-state and output logic
  cnt_t rep_last;
  logic press_done, release_done, repeat_hit;
  assign rep_last     = first_q ? PERIOD_LAST : DELAY_LAST;
  assign press_done   = s2_q && (cnt_q == DEB_LAST);
  assign release_done = !s2_q && (cnt_q == DEB_LAST);
  assign repeat_hit   = s2_q && (rcnt_q == rep_last);

  // Two-flop synchroniser for the asynchronous button level
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      // NOTE: non-blocking so s2 takes the old s1, forming a real two-stage chain.
      s1_q <= btn_raw_i;
      s2_q <= s1_q;
    end
  end

  // State register, counters and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: every flop is cleared here so outputs drop the instant reset asserts.
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rcnt_q  <= '0;
      first_q <= 1'b0;
      dpb_q   <= 1'b0;
      scen_q  <= 1'b0;
      mcen_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rcnt_q  <= rcnt_d;
      first_q <= first_d;
      dpb_q   <= dpb_d;
      scen_q  <= scen_d;
      mcen_q  <= mcen_d;
    end
  end

  // Next-state and counter update
  always_comb begin
    // NOTE: defaults first on every variable so no path leaves one unassigned (no latch).
    state_d = state_q;
    cnt_d   = cnt_q;
    rcnt_d  = rcnt_q;
    first_d = first_q;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (s2_q) begin
          state_d = ST_PRESS_WAIT;
          cnt_d   = cnt_t'(1);
        end
      end
      ST_PRESS_WAIT: begin
        if (!s2_q) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (press_done) begin
          state_d = ST_HELD;
          cnt_d   = '0;
          rcnt_d  = '0;
          first_d = 1'b0;
        end else begin
          cnt_d = cnt_q + cnt_t'(1);
        end
      end
      ST_HELD: begin
        if (!s2_q) begin
          state_d = ST_RELEASE_WAIT;
          cnt_d   = cnt_t'(1);
        end else if (repeat_hit) begin
          rcnt_d  = '0;
          first_d = 1'b1;
        end else begin
          rcnt_d = rcnt_q + cnt_t'(1);
        end
      end
      ST_RELEASE_WAIT: begin
        if (s2_q) begin
          state_d = ST_HELD;
        end else if (release_done) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + cnt_t'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        rcnt_d  = '0;
        first_d = 1'b0;
      end
    endcase
  end

  // Output decode, registered one edge later
  always_comb begin
    dpb_d  = 1'b0;
    scen_d = 1'b0;
    mcen_d = 1'b0;
    case (state_q)
      ST_PRESS_WAIT: begin
        if (press_done) begin
          dpb_d  = 1'b1;
          scen_d = 1'b1;
          mcen_d = 1'b1;
        end
      end
      ST_HELD: begin
        dpb_d  = 1'b1;
        mcen_d = repeat_hit;
      end
      ST_RELEASE_WAIT: dpb_d = !release_done;
      default: ;
    endcase
  end

  assign dpb_o  = dpb_q;
  assign scen_o = scen_q;
  assign mcen_o = mcen_q;

endmodule

// File: rtl/button_conditioner.sv
// N independent button channels; the top only replicates and concatenates.
module button_conditioner
  import game_io_pkg::*;
#(
  parameter int N_BTN           = DEFAULT_N_BTN,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEFAULT_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEFAULT_REPEAT_PERIOD
) (
  input  logic                 clk,
  input  logic                 reset,   // asynchronous, active-low
  button_conditioner_if.slave  bus
);

  logic [N_BTN-1:0] dpbs, scens, mcens;

  // One conditioner per button
  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD)
    ) u_ch (
      .clk       (clk),
      .reset     (reset),
      .btn_raw_i (bus.btn_raw[i]),
      .dpb_o     (dpbs[i]),
      .scen_o    (scens[i]),
      .mcen_o    (mcens[i])
    );
  end

  assign bus.DPBs  = dpbs;
  assign bus.SCENs = scens;
  assign bus.MCENs = mcens;

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: directed scenarios plus random button traffic,
// every cycle compared against a behavioural model of the conditioning rules.
module tb_button_conditioner;
  import game_io_pkg::*;

  localparam int NB  = 4;
  localparam int DEB = 4;
  localparam int RD  = 8;
  localparam int RP  = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  button_conditioner_if #(.N_BTN(NB)) bus ();

  button_conditioner #(
    .N_BTN           (NB),
    .DEBOUNCE_CYCLES (DEB),
    .REPEAT_DELAY    (RD),
    .REPEAT_PERIOD   (RP)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // ---------------- behavioural model ----------------
  // Each button: a two-sample delay, an accepted level, a run length of
  // consecutive samples that disagree with that level, and the number of
  // held cycles since the last press or repeat pulse.
  bit        m_p1[NB], m_p2[NB];
  bit        m_level[NB];
  int        m_run[NB];
  int        m_phase[NB];
  bit        m_first[NB];
  logic [NB-1:0] m_dpb, m_scen, m_mcen;

  task automatic model_reset();
    for (int i = 0; i < NB; i++) begin
      m_p1[i] = 0; m_p2[i] = 0; m_level[i] = 0;
      m_run[i] = 0; m_phase[i] = 0; m_first[i] = 0;
    end
    m_dpb = '0; m_scen = '0; m_mcen = '0;
  endtask

  task automatic model_step(input logic [NB-1:0] b);
    bit s;
    for (int i = 0; i < NB; i++) begin
      s = m_p2[i];
      m_p2[i] = m_p1[i];
      m_p1[i] = b[i];
      m_scen[i] = 1'b0;
      m_mcen[i] = 1'b0;
      if (!m_level[i]) begin
        if (s) begin
          m_run[i]++;
          if (m_run[i] == DEB) begin
            m_level[i] = 1; m_run[i] = 0; m_phase[i] = 0; m_first[i] = 0;
            m_scen[i] = 1'b1; m_mcen[i] = 1'b1;
          end
        end else m_run[i] = 0;
      end else begin
        if (!s) begin
          m_run[i]++;
          if (m_run[i] == DEB) begin
            m_level[i] = 0; m_run[i] = 0;
          end
        end else if (m_run[i] > 0) begin
          m_run[i] = 0;               // rejected release: repeat phase frozen
        end else begin
          m_phase[i]++;
          if (m_phase[i] == (m_first[i] ? RP : RD)) begin
            m_phase[i] = 0; m_first[i] = 1; m_mcen[i] = 1'b1;
          end
        end
      end
      m_dpb[i] = m_level[i];
    end
  endtask

  // ---------------- observation bookkeeping ----------------
  int            edge_no = 0;
  int            first_sc[NB], first_fall[NB], cnt_sc[NB], cnt_mc[NB];
  logic [NB-1:0] prev_dpb = '0;

  task automatic clear_obs();
    for (int i = 0; i < NB; i++) begin
      first_sc[i] = -1; first_fall[i] = -1; cnt_sc[i] = 0; cnt_mc[i] = 0;
    end
  endtask

  // One clock: drive at negedge, model at posedge, compare 1 time unit later
  task automatic cycle(input logic [NB-1:0] b);
    bus.btn_raw = b;
    @(posedge clk);
    edge_no++;
    model_step(b);
    #1;
    check("dpbs",  bus.DPBs,  m_dpb);
    check("scens", bus.SCENs, m_scen);
    check("mcens", bus.MCENs, m_mcen);
    for (int i = 0; i < NB; i++) begin
      if (bus.SCENs[i]) begin
        cnt_sc[i]++;
        if (first_sc[i] < 0) first_sc[i] = edge_no;
      end
      if (bus.MCENs[i]) cnt_mc[i]++;
      if (prev_dpb[i] && !bus.DPBs[i] && first_fall[i] < 0) first_fall[i] = edge_no;
    end
    prev_dpb = bus.DPBs;
    @(negedge clk);
  endtask

  task automatic hold(input logic [NB-1:0] b, input int n);
    for (int k = 0; k < n; k++) cycle(b);
  endtask

  int            e;
  logic [NB-1:0] cur;
  int            rem[NB];

  initial begin
    reset = 1'b0;
    bus.btn_raw = '0;
    model_reset();
    clear_obs();
    #1;
    check("rst_dpbs",  bus.DPBs,  '0);
    check("rst_scens", bus.SCENs, '0);
    check("rst_mcens", bus.MCENs, '0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    hold('0, 3);

    // Clean press on button 0
    clear_obs();
    e = edge_no + 1;
    hold(4'b0001, 10);
    check("press_latency", first_sc[0] - e, DEB + 1);
    check("press_once", cnt_sc[0], 1);
    check("press_isolated", cnt_sc[1] + cnt_sc[2] + cnt_sc[3], 0);

    // Bounce on button 1: 3 high, 1 low, then steady
    clear_obs();
    hold(4'b0011, 3);
    hold(4'b0001, 1);
    e = edge_no + 1;
    hold(4'b0011, 10);
    check("bounce_latency", first_sc[1] - e, DEB + 1);
    check("bounce_once", cnt_sc[1], 1);

    // Auto-repeat on button 2: press + 30 held cycles
    clear_obs();
    e = edge_no + 1;
    hold(4'b0111, DEB + 1 + 31);
    check("repeat_first", first_sc[2] - e, DEB + 1);
    check("repeat_scen_once", cnt_sc[2], 1);
    check("repeat_mcen_count", cnt_mc[2], 9);   // +0,8,11,14,17,20,23,26,29

    // Release glitch on button 3, then a full release
    hold(4'b1111, 10);
    clear_obs();
    hold(4'b0111, 2);
    hold(4'b1111, 8);
    check("glitch_no_fall", first_fall[3], -1);
    check("glitch_no_scen", cnt_sc[3], 0);
    clear_obs();
    e = edge_no + 1;
    hold(4'b0111, 6);
    check("release_latency", first_fall[3] - e, DEB + 1);

    // Asynchronous reset mid-hold
    check("pre_reset_dpb0", bus.DPBs[0], 1'b1);
    #2 reset = 1'b0;
    #1;
    check("async_dpbs",  bus.DPBs,  '0);
    check("async_scens", bus.SCENs, '0);
    check("async_mcens", bus.MCENs, '0);
    model_reset();
    prev_dpb = '0;
    @(posedge clk);
    #1;
    check("in_reset_dpbs", bus.DPBs, '0);
    @(negedge clk);
    reset = 1'b1;
    clear_obs();
    e = edge_no + 1;
    hold(4'b0111, 10);
    check("post_reset_latency", first_sc[0] - e, DEB + 1);

    // Simultaneous press on all buttons
    hold('0, 8);
    clear_obs();
    e = edge_no + 1;
    hold(4'b1111, 10);
    for (int i = 0; i < NB; i++) check("simul_latency", first_sc[i] - e, DEB + 1);

    // Random traffic: mostly short bounces, sometimes long holds
    cur = '0;
    for (int i = 0; i < NB; i++) rem[i] = 1;
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < NB; i++) begin
        rem[i]--;
        if (rem[i] <= 0) begin
          cur[i] = ~cur[i];
          rem[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(20, 40))
                                               : int'($urandom_range(1, 6));
        end
      end
      cycle(cur);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
